// File: rtl/bluetooth.sv
// UART 8N1 receiver for an HC-05 class module; each correctly framed byte is latched onto the LED bank.
// Optional 8E1 framing with even-parity check when BLUETOOTH_PARITY_EN is defined.
module bluetooth #(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int BAUD_RATE   = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] leds
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 4095) ? $clog2(CLKS_PER_BIT) : 12;

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
    localparam logic [2:0] PARITY = 3'd4;

    logic             rx_m;
    logic             rx_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             bit_done;
`ifdef BLUETOOTH_PARITY_EN
    logic             par_bad;
`endif

    assign bit_done = (cnt == BIT_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            leds    <= '0;
`ifdef BLUETOOTH_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == HALF_END) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // A high line at mid start bit means the low was only a glitch.
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
`ifdef BLUETOOTH_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef BLUETOOTH_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        cnt     <= '0;
                        par_bad <= ^{shift, rx_s};
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        cnt <= '0;
                        // Leave at mid stop bit so a back-to-back start edge is not missed.
                        state <= IDLE;
`ifdef BLUETOOTH_PARITY_EN
                        if (rx_s && !par_bad) leds <= shift;
`else
                        if (rx_s) leds <= shift;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bluetooth.sv
// Self-checking bench for bluetooth: a frame-level model predicts when and to what leds must change.
// The DUT runs at 25 clocks per bit so that many frames fit in a short run.
module tb_bluetooth;

    localparam int CPB  = 25;
    localparam int HALF = CPB / 2;
`ifdef BLUETOOTH_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    // Start edge to leds update: 2 sync + half bit + data(+parity)+stop bit times + 1.
    localparam int LAT = 2 + HALF + NBITS * CPB + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] leds;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0] exp_leds = 8'h00;
    logic       armed = 1'b0;
    logic       rst_seen;
    int         sched_cyc_q[$];
    logic [7:0] exp_q[$];

    always #20 clk = ~clk;

    bluetooth #(
        .CLK_FREQ_HZ(25_000_000),
        .BAUD_RATE  (1_000_000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rx   (rx),
        .leds (leds)
    );

    // Model update and per-cycle compare, 1 ns after each rising edge.
    always @(posedge clk) begin
        rst_seen = reset;
        cyc = cyc + 1;
        #1;
        if (rst_seen) begin
            exp_leds = 8'h00;
            sched_cyc_q.delete();
            exp_q.delete();
            armed = 1'b1;
        end else if (sched_cyc_q.size() > 0 && sched_cyc_q[0] == cyc) begin
            exp_leds = exp_q.pop_front();
            void'(sched_cyc_q.pop_front());
        end
        if (armed) begin
            checks++;
            if (leds !== exp_leds) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL leds_model cyc=%0d got=%02h exp=%02h", cyc, leds, exp_leds);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_err);
        if (stop_ok && !par_err) begin
            sched_cyc_q.push_back(cyc + LAT);
            exp_q.push_back(b);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef BLUETOOTH_PARITY_EN
        drive_bit((^b) ^ par_err);
`endif
        drive_bit(stop_ok);
        rx = 1'b1;
    endtask

    task automatic glitch(input int len);
        rx = 1'b0;
        repeat (len) @(negedge clk);
        rx = 1'b1;
        idle(CPB);
    endtask

    // Held low across m phantom frames; released just after a failed stop sample.
    task automatic break_line(input int m);
        rx = 1'b0;
        repeat (m * (LAT - 2) + LAT + 4) @(negedge clk);
        rx = 1'b1;
        idle(2 * CPB);
    endtask

    task automatic reset_mid_frame(input logic [7:0] b);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        repeat (HALF) @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(2 * CPB);
    endtask

    task automatic check_lit(input string name, input logic [7:0] v);
        checks++;
        if (leds !== v) begin
            errors++;
            $display("FAIL %s got=%02h exp=%02h", name, leds, v);
        end
    endtask

    initial begin
        logic [7:0] held;
        logic [7:0] b;
        int r;
        reset = 1'b1;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_lit("reset", 8'h00);
        idle(500);
        check_lit("idle_hold", 8'h00);

        send_frame(8'hFF, 1'b1, 1'b0);
        check_lit("all_ones", 8'hFF);
        send_frame(8'h5A, 1'b1, 1'b0);
        check_lit("b2b_first", 8'h5A);
        send_frame(8'hA5, 1'b1, 1'b0);
        check_lit("b2b_second", 8'hA5);
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(2 * CPB);
        check_lit("bad_stop", 8'hA5);
        glitch(8);
        check_lit("false_start", 8'hA5);
        send_frame(8'h81, 1'b1, 1'b0);
        check_lit("after_glitch", 8'h81);
        reset_mid_frame(8'h7E);
        check_lit("reset_abort", 8'h00);
        send_frame(8'h7E, 1'b1, 1'b0);
        check_lit("after_abort", 8'h7E);
        held = 8'h7E;
`ifdef BLUETOOTH_PARITY_EN
        send_frame(8'h11, 1'b1, 1'b0);
        check_lit("parity_ok", 8'h11);
        send_frame(8'h7E, 1'b1, 1'b1);
        check_lit("parity_bad", 8'h11);
        held = 8'h11;
`endif
        break_line(2);
        check_lit("break", held);

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                glitch($urandom_range(1, HALF - 4));
            end else begin
                b = 8'($urandom);
`ifdef BLUETOOTH_PARITY_EN
                send_frame(b, r != 1, r == 2);
`else
                send_frame(b, r != 1, 1'b0);
`endif
                if (r == 1) idle(2 * CPB);
                else idle($urandom_range(0, 3));
            end
        end

        idle(LAT + 10);
        checks++;
        if (sched_cyc_q.size() != 0) begin
            errors++;
            $display("FAIL pending_updates got=%0d exp=0", sched_cyc_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #10ms;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench time limit expired");
    end

endmodule
